perf_counter_bank: RTL and testbench

Parametrised bank of event/cycle counters for core performance monitoring; the multi-channel successor to the single free-running cycle counter. Each channel counts either every clock or one selected event line, with its own start/stop/clear control, wrap or saturate on overflow, and sticky overflow flags feeding one interrupt. Software and the debug path read counters through a registered read port. A bank-wide snapshot freezes all channels coherently.

---
 rtl/perf_pkg.sv | 16 +
 rtl/perf_counter_channel.sv | 75 +++++++
 rtl/perf_counter_bank.sv | 112 +++++++++++
 tb/tb_perf_counter_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and width helpers for the performance counter bank
package perf_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;

  // Select codes 0..num_evt-1 pick an event line, num_evt means every cycle.
  function automatic int sel_width(int num_evt);
    return $clog2(num_evt + 1);
  endfunction

  function automatic int idx_width(int num_cnt);
    return (num_cnt > 1) ? $clog2(num_cnt) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// rtl/perf_counter_channel.sv - one counter channel: IDLE/RUN control, counter, config, sticky overflow
module perf_counter_channel
  import perf_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int SEL_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic             cfg_sat,
  output logic [CNT_W-1:0] count,
  output logic [SEL_W-1:0] sel,
  output logic             ovf,
  output logic             running
);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic [CNT_W-1:0]   count_q;
  logic [SEL_W-1:0]   sel_q;
  logic               ovf_q;
  logic               inc;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Start beats stop; the counting decision uses the state held before the edge.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    if (start)     state_d = ST_RUN;
    else if (stop) state_d = ST_IDLE;
    inc = (state_q == ST_RUN) && hit && !clear;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      sel_q   <= SEL_W'(NUM_EVT);
      mode_q  <= MODE_WRAP;
    end else begin
      if (cfg_we && state_q == ST_IDLE) begin
        sel_q  <= cfg_sel;
        mode_q <= cfg_sat ? MODE_SAT : MODE_WRAP;
      end
      if (clear) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (inc) begin
        if (&count_q) begin
          ovf_q <= 1'b1;
          if (mode_q == MODE_WRAP) count_q <= '0;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  assign count   = count_q;
  assign sel     = sel_q;
  assign ovf     = ovf_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event/cycle counters with event mux, snapshot shadows, read port, irq
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CNT = 4,
  parameter  int CNT_W   = 32,
  parameter  int NUM_EVT = 8,
  localparam int IDX_W   = idx_width(NUM_CNT),
  localparam int SEL_W   = sel_width(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] event_i,
  input  logic [NUM_CNT-1:0] start_i,
  input  logic [NUM_CNT-1:0] stop_i,
  input  logic [NUM_CNT-1:0] clear_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic               cfg_sat_i,
  input  logic               snap_i,
  input  logic               rd_en_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  input  logic               rd_shadow_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_CNT-1:0] running_o,
  output logic [NUM_CNT-1:0] ovf_o,
  output logic               irq_o
);

  logic [CNT_W-1:0] cnt_w    [NUM_CNT];
  logic [CNT_W-1:0] shadow_q [NUM_CNT];
  logic [SEL_W-1:0] sel_w    [NUM_CNT];
  logic             ovf_w    [NUM_CNT];
  logic             run_w    [NUM_CNT];
  logic [NUM_CNT-1:0] hit;
  logic [NUM_CNT-1:0] cfg_hit;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             irq_q;

  // Select codes above NUM_EVT match nothing and so never hit.
  always_comb begin
    hit     = '0;
    cfg_hit = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(sel_w[i]) == NUM_EVT) begin
        hit[i] = 1'b1;
      end else begin
        for (int e = 0; e < NUM_EVT; e++)
          if (int'(sel_w[i]) == e) hit[i] = event_i[e];
      end
      cfg_hit[i] = cfg_we_i && (int'(cfg_idx_i) == i);
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ch
    perf_counter_channel #(
      .CNT_W  (CNT_W),
      .NUM_EVT(NUM_EVT),
      .SEL_W  (SEL_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .hit    (hit[g]),
      .start  (start_i[g]),
      .stop   (stop_i[g]),
      .clear  (clear_i[g]),
      .cfg_we (cfg_hit[g]),
      .cfg_sel(cfg_sel_i),
      .cfg_sat(cfg_sat_i),
      .count  (cnt_w[g]),
      .sel    (sel_w[g]),
      .ovf    (ovf_w[g]),
      .running(run_w[g])
    );
  end

  always_comb begin
    ovf_o     = '0;
    running_o = '0;
    rd_mux    = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      ovf_o[i]     = ovf_w[i];
      running_o[i] = run_w[i];
      if (int'(rd_idx_i) == i) rd_mux = rd_shadow_i ? shadow_q[i] : cnt_w[i];
    end
  end

  // Shadows take the pre-edge counts, so a snapshot is coherent across channels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (snap_i)
        for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt_w[i];
      rd_valid_q <= rd_en_i;
      rd_data_q  <= rd_en_i ? rd_mux : '0;
      irq_q      <= |ovf_o;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank (4 channels, 8-bit counters, 8 events)
module tb_perf_counter_bank;

  localparam int NUM_CNT = 4;
  localparam int CNT_W   = 8;
  localparam int NUM_EVT = 8;

  logic               clk;
  logic               rst;
  logic [NUM_EVT-1:0] event_i;
  logic [NUM_CNT-1:0] start_i, stop_i, clear_i;
  logic               cfg_we_i;
  logic [1:0]         cfg_idx_i;
  logic [3:0]         cfg_sel_i;
  logic               cfg_sat_i;
  logic               snap_i;
  logic               rd_en_i;
  logic [1:0]         rd_idx_i;
  logic               rd_shadow_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic               rd_valid_o;
  logic [NUM_CNT-1:0] running_o;
  logic [NUM_CNT-1:0] ovf_o;
  logic               irq_o;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_q [$];

  perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dut (
    .clk(clk), .rst(rst), .event_i(event_i), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_sel_i(cfg_sel_i),
    .cfg_sat_i(cfg_sat_i), .snap_i(snap_i), .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .rd_shadow_i(rd_shadow_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .running_o(running_o), .ovf_o(ovf_o), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge, so one step spans exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] idx, input logic sh, input logic [CNT_W-1:0] exp);
    rd_en_i = 1'b1; rd_idx_i = idx; rd_shadow_i = sh;
    exp_q.push_back(exp);
    step();
    rd_en_i = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [3:0] sel, input logic sat);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_sel_i = sel; cfg_sat_i = sat;
    step();
    cfg_we_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_valid_o) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", rd_data_o, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; event_i = '0; start_i = '0; stop_i = '0; clear_i = '0;
    cfg_we_i = 0; cfg_idx_i = 0; cfg_sel_i = 0; cfg_sat_i = 0; snap_i = 0;
    rd_en_i = 0; rd_idx_i = 0; rd_shadow_i = 0;
    steps(3);
    chk("rst_running", running_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    rst = 1'b1;
    step();

    // ch0 counts every cycle for 10 edges
    start_i[0] = 1; step(); start_i[0] = 0;
    chk("ch0_running", running_o[0], 1);
    steps(9);
    stop_i[0] = 1; step(); stop_i[0] = 0;
    chk("ch0_stopped", running_o[0], 0);
    rd(0, 0, 8'd10);

    // ch1 on event 3; other events and idle pulses must not count
    cfg(1, 4'd3, 0);
    start_i[1] = 1; step(); start_i[1] = 0;
    for (int i = 0; i < 5; i++) begin
      event_i[3] = 1; step(); event_i[3] = 0; step();
    end
    for (int i = 0; i < 2; i++) begin
      event_i[2] = 1; step(); event_i[2] = 0; step();
    end
    stop_i[1] = 1; step(); stop_i[1] = 0;
    for (int i = 0; i < 3; i++) begin
      event_i[3] = 1; step(); event_i[3] = 0; step();
    end
    rd(1, 0, 8'd5);

    // ch2 wrap: 256 increments
    cfg(2, 4'd8, 0);
    start_i[2] = 1; step(); start_i[2] = 0;
    steps(255);
    stop_i[2] = 1; step(); stop_i[2] = 0;
    chk("wrap_ovf", ovf_o[2], 1);
    chk("wrap_irq_lag", irq_o, 0);
    step();
    chk("wrap_irq", irq_o, 1);
    rd(2, 0, 8'd0);
    clear_i[2] = 1; step(); clear_i[2] = 0;
    chk("clr_ovf", ovf_o[2], 0);
    step();
    chk("clr_irq", irq_o, 0);

    // ch2 saturate: 260 increments
    cfg(2, 4'd8, 1);
    start_i[2] = 1; step(); start_i[2] = 0;
    steps(259);
    stop_i[2] = 1; step(); stop_i[2] = 0;
    chk("sat_ovf", ovf_o[2], 1);
    rd(2, 0, 8'd255);
    clear_i[2] = 1; step(); clear_i[2] = 0;
    rd(2, 0, 8'd0);
    chk("sat_clr_ovf", ovf_o[2], 0);

    // start+stop together, from IDLE and from RUN; clear+start
    start_i[3] = 1; stop_i[3] = 1; step();
    chk("ss_idle", running_o[3], 1);
    step();
    chk("ss_run", running_o[3], 1);
    start_i[3] = 0; stop_i[3] = 0;
    steps(3);
    clear_i[3] = 1; start_i[3] = 1; step(); clear_i[3] = 0; start_i[3] = 0;
    chk("clr_start_run", running_o[3], 1);
    stop_i[3] = 1; rd(3, 0, 8'd0); stop_i[3] = 0;
    rd(3, 0, 8'd1);

    // cfg to a running channel ignored; snapshot at 7, live continues to 12
    clear_i[0] = 1; start_i[0] = 1; step(); clear_i[0] = 0; start_i[0] = 0;
    cfg(0, 4'd5, 0);
    steps(6);
    snap_i = 1; step(); snap_i = 0;
    steps(3);
    stop_i[0] = 1; step(); stop_i[0] = 0;
    rd(0, 1, 8'd7);
    rd(0, 0, 8'd12);
    rd(1, 1, 8'd5);
    rd(3, 1, 8'd1);
    clear_i[0] = 1; start_i[0] = 1; step(); clear_i[0] = 0; start_i[0] = 0;
    steps(4);
    stop_i[0] = 1; step(); stop_i[0] = 0;
    rd(0, 0, 8'd5);

    // reset mid-count with a read in flight
    start_i[0] = 1; start_i[2] = 1; step(); start_i = '0;
    steps(3);
    rst = 0; rd_en_i = 1; rd_idx_i = 0; rd_shadow_i = 0; step();
    rd_en_i = 0;
    chk("mid_rst_valid", rd_valid_o, 0);
    chk("mid_rst_data", rd_data_o, 0);
    chk("mid_rst_running", running_o, 0);
    chk("mid_rst_ovf", ovf_o, 0);
    chk("mid_rst_irq", irq_o, 0);
    rst = 1;
    rd(0, 0, 8'd0);
    rd(0, 1, 8'd0);
    rd(2, 0, 8'd0);
    steps(2);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
